// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SD-card SPI-mode responder.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  // R1 = {0, param_err, addr_err, erase_seq, crc_err, illegal, erase_reset, idle}
  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam int         RESP_W       = 48;
  localparam logic [5:0] RESP_LEN_R1  = 6'd8;
  localparam logic [5:0] RESP_LEN_R7  = 6'd40;
  localparam logic [5:0] RESP_LEN_R3  = 6'd40;
  localparam logic [5:0] RESP_LEN_MAX = 6'd48;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NCR,
    S_SEND
  } state_e;

endpackage

// File: rtl/sd_resp_shifter.sv
// Left-aligned response shift register; done pulses on the strobe that retires the last bit.
module sd_resp_shifter
  import sd_spi_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [RESP_W-1:0] load_data,
  input  logic [5:0]        load_len,
  input  logic              shift_en,
  output logic              msb,
  output logic              done
);

  logic [RESP_W-1:0] data_q, data_d;
  logic [5:0]        cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = load_len;
    end else if (shift_en && (cnt_q != 6'd0)) begin
      data_d = {data_q[RESP_W-2:0], 1'b0};
      cnt_d  = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign msb  = data_q[RESP_W-1];
  assign done = shift_en && (cnt_q == 6'd1);

endmodule

// File: rtl/sd_spi_responder.sv
// SD SPI-mode responder: tracks idle/APP_CMD state and serialises R1/R7(/R3) after an Ncr gap.
// Defining SD_RESP_CMD58_EN adds CMD58 (R3 with OCR); otherwise CMD58 is illegal.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned NCR_BYTES      = 1,
  parameter int unsigned ACMD41_RETRIES = 2,
  parameter logic [31:0] OCR_VALUE      = 32'hC0FF8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_CS,
  input  logic        io_ShiftStrobe,
  input  logic        io_CommandReadFinished,
  input  logic        io_ReadSuccess,
  input  logic [5:0]  io_Command,
  input  logic [31:0] io_CommandArgument,
  output logic        io_DO,
  output logic        io_Busy,
  output logic        io_InIdle,
  output logic        io_AppCmd,
  output logic        io_Dropped
);

  localparam logic [6:0] NCR_BITS  = 7'(8 * NCR_BYTES);
  localparam logic [7:0] RETRY_MAX = 8'(ACMD41_RETRIES);

  state_e      state_q, state_d;
  logic [6:0]  ncr_cnt_q, ncr_cnt_d;
  logic        idle_q, idle_d;
  logic        app_cmd_q, app_cmd_d;
  logic [7:0]  retry_q, retry_d;
  logic        dropped_q, dropped_d;

  logic        accept;
  logic        idle_new, app_cmd_new;
  logic [7:0]  retry_new;
  logic [7:0]  r1;
  logic [39:0] resp_tail;
  logic [5:0]  resp_len;
  logic        shift_load, shift_en, shift_msb, shift_done;

  assign accept = (state_q == S_IDLE) && io_CommandReadFinished && !io_CS;

  // Candidate response and flag updates; only committed when the command is accepted.
  always_comb begin
    idle_new    = idle_q;
    app_cmd_new = 1'b0;
    retry_new   = retry_q;
    r1          = '0;
    resp_tail   = '0;
    resp_len    = RESP_LEN_R1;
    if (!io_ReadSuccess) begin
      r1[R1_CRC_ERR] = 1'b1;
    end else if (io_Command == CMD0) begin
      idle_new  = 1'b1;
      retry_new = '0;
    end else if (io_Command == CMD8) begin
      resp_len  = RESP_LEN_R7;
      resp_tail = {16'h0000, 4'h0, io_CommandArgument[11:0], 8'h00};
    end else if (io_Command == CMD55) begin
      app_cmd_new = 1'b1;
    end else if ((io_Command == CMD41) && app_cmd_q) begin
      if (retry_q < RETRY_MAX) begin
        retry_new = retry_q + 8'd1;
      end else begin
        idle_new = 1'b0;
      end
    end else if (io_Command == CMD16) begin
      resp_len = RESP_LEN_R1;
`ifdef SD_RESP_CMD58_EN
    end else if (io_Command == CMD58) begin
      resp_len  = RESP_LEN_R3;
      resp_tail = {!idle_q, OCR_VALUE[30:0], 8'h00};
`endif
    end else begin
      r1[R1_ILLEGAL] = 1'b1;
    end
    r1[R1_IDLE] = idle_new;
  end

  always_comb begin
    state_d    = state_q;
    ncr_cnt_d  = ncr_cnt_q;
    idle_d     = idle_q;
    app_cmd_d  = app_cmd_q;
    retry_d    = retry_q;
    shift_load = 1'b0;
    shift_en   = 1'b0;
    dropped_d  = (state_q != S_IDLE) && io_CommandReadFinished && !io_CS;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_NCR;
          ncr_cnt_d  = NCR_BITS;
          shift_load = 1'b1;
          idle_d     = idle_new;
          app_cmd_d  = app_cmd_new;
          retry_d    = retry_new;
        end
      end
      S_NCR: begin
        if (io_ShiftStrobe) begin
          ncr_cnt_d = ncr_cnt_q - 7'd1;
          if (ncr_cnt_q == 7'd1) state_d = S_SEND;
        end
      end
      S_SEND: begin
        shift_en = io_ShiftStrobe;
        if (shift_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Master released the card: abandon the response, keep any flag changes.
    if ((state_q != S_IDLE) && io_CS) state_d = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ncr_cnt_q <= '0;
      idle_q    <= 1'b1;
      app_cmd_q <= 1'b0;
      retry_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ncr_cnt_q <= ncr_cnt_d;
      idle_q    <= idle_d;
      app_cmd_q <= app_cmd_d;
      retry_q   <= retry_d;
      dropped_q <= dropped_d;
    end
  end

  sd_resp_shifter u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (shift_load),
    .load_data ({r1, resp_tail}),
    .load_len  (resp_len),
    .shift_en  (shift_en),
    .msb       (shift_msb),
    .done      (shift_done)
  );

  assign io_DO      = (state_q == S_SEND) ? shift_msb : 1'b1;
  assign io_Busy    = (state_q != S_IDLE);
  assign io_InIdle  = idle_q;
  assign io_AppCmd  = app_cmd_q;
  assign io_Dropped = dropped_q;

  logic unused_arg;
  assign unused_arg = ^io_CommandArgument[31:12];
`ifndef SD_RESP_CMD58_EN
  logic unused_ocr;
  assign unused_ocr = ^OCR_VALUE;
`endif

endmodule

// File: tb/tb_sd_spi_responder.sv
// Randomised self-checking bench for sd_spi_responder against a byte-level card model.
module tb_sd_spi_responder;

  localparam int unsigned TB_NCR     = 1;
  localparam int unsigned TB_RETRIES = 2;
  localparam logic [31:0] TB_OCR     = 32'hC0FF8000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_CS = 1'b1;
  logic        io_ShiftStrobe = 1'b0;
  logic        io_CommandReadFinished = 1'b0;
  logic        io_ReadSuccess = 1'b1;
  logic [5:0]  io_Command = '0;
  logic [31:0] io_CommandArgument = '0;
  logic        io_DO, io_Busy, io_InIdle, io_AppCmd, io_Dropped;

  always #5 clock = ~clock;

  sd_spi_responder #(
    .NCR_BYTES      (TB_NCR),
    .ACMD41_RETRIES (TB_RETRIES),
    .OCR_VALUE      (TB_OCR)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_CS                  (io_CS),
    .io_ShiftStrobe         (io_ShiftStrobe),
    .io_CommandReadFinished (io_CommandReadFinished),
    .io_ReadSuccess         (io_ReadSuccess),
    .io_Command             (io_Command),
    .io_CommandArgument     (io_CommandArgument),
    .io_DO                  (io_DO),
    .io_Busy                (io_Busy),
    .io_InIdle              (io_InIdle),
    .io_AppCmd              (io_AppCmd),
    .io_Dropped             (io_Dropped)
  );

  int checks = 0;
  int errors = 0;

  // Card model: flags plus the expected byte stream (Ncr filler included).
  bit         m_idle;
  bit         m_app;
  int         m_retry;
  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_app   = 1'b0;
    m_retry = 0;
  endtask

  task automatic model_cmd(input logic [5:0] cmd, input logic [31:0] arg, input bit ok);
    bit          was_app;
    logic [31:0] ocr;
    was_app = m_app;
    m_app   = 1'b0;
    ocr     = TB_OCR;
    exp_q.delete();
    for (int i = 0; i < int'(TB_NCR); i++) exp_q.push_back(8'hFF);
    if (!ok) begin
      exp_q.push_back(8'h08 | {7'd0, m_idle});
    end else if (cmd == 6'd0) begin
      m_idle  = 1'b1;
      m_retry = 0;
      exp_q.push_back(8'h01);
    end else if (cmd == 6'd8) begin
      exp_q.push_back({7'd0, m_idle});
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back({4'h0, arg[11:8]});
      exp_q.push_back(arg[7:0]);
    end else if (cmd == 6'd55) begin
      m_app = 1'b1;
      exp_q.push_back({7'd0, m_idle});
    end else if (cmd == 6'd41 && was_app) begin
      if (m_retry < int'(TB_RETRIES)) begin
        m_retry++;
        exp_q.push_back(8'h01);
      end else begin
        m_idle = 1'b0;
        exp_q.push_back(8'h00);
      end
    end else if (cmd == 6'd16) begin
      exp_q.push_back({7'd0, m_idle});
`ifdef SD_RESP_CMD58_EN
    end else if (cmd == 6'd58) begin
      ocr[31] = !m_idle;
      exp_q.push_back({7'd0, m_idle});
      exp_q.push_back(ocr[31:24]);
      exp_q.push_back(ocr[23:16]);
      exp_q.push_back(ocr[15:8]);
      exp_q.push_back(ocr[7:0]);
`endif
    end else begin
      exp_q.push_back(8'h04 | {7'd0, m_idle});
    end
  endtask

  task automatic strobe_bit();
    repeat ($urandom_range(0, 2)) tick();
    io_ShiftStrobe = 1'b1;
    tick();
    io_ShiftStrobe = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      b[i] = io_DO;
      strobe_bit();
    end
  endtask

  task automatic read_range(input int lo, input int hi, input string name);
    logic [7:0] b;
    for (int i = lo; i < hi; i++) begin
      read_byte(b);
      checks++;
      if (b !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %02h expected %02h", name, i, b, exp_q[i]);
      end
    end
  endtask

  task automatic start_cmd(input logic [5:0] cmd, input logic [31:0] arg, input bit ok, input bit with_strobe);
    io_Command             = cmd;
    io_CommandArgument     = arg;
    io_ReadSuccess         = ok;
    io_CommandReadFinished = 1'b1;
    io_ShiftStrobe         = with_strobe;
    tick();
    io_CommandReadFinished = 1'b0;
    io_ShiftStrobe         = 1'b0;
  endtask

  task automatic check_end(input string name);
    checks++;
    if ({io_Busy, io_DO, io_InIdle, io_AppCmd} !== {1'b0, 1'b1, m_idle, m_app}) begin
      errors++;
      $display("FAIL %s end: busy/do/idle/app got %b expected %b", name,
               {io_Busy, io_DO, io_InIdle, io_AppCmd}, {1'b0, 1'b1, m_idle, m_app});
    end
  endtask

  task automatic run_cmd(input logic [5:0] cmd, input logic [31:0] arg, input bit ok, input bit with_strobe);
    model_cmd(cmd, arg, ok);
    start_cmd(cmd, arg, ok, with_strobe);
    checks++;
    if (io_Busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start cmd%0d: got %b expected 1", cmd, io_Busy);
    end
    read_range(0, exp_q.size(), $sformatf("cmd%0d", cmd));
    check_end($sformatf("cmd%0d", cmd));
    $display("txn cmd=%0d arg=%08h ok=%0d strobe=%0d bytes=%0d idle=%0b app=%0b",
             cmd, arg, ok, with_strobe, exp_q.size(), m_idle, m_app);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io_CS = 1'b1;
    repeat (3) tick();
    checks++;
    if ({io_DO, io_Busy, io_InIdle, io_AppCmd, io_Dropped} !== 5'b10100) begin
      errors++;
      $display("FAIL reset: do/busy/idle/app/drop got %b expected 10100",
               {io_DO, io_Busy, io_InIdle, io_AppCmd, io_Dropped});
    end
    reset = 1'b1;
    io_CS = 1'b0;
    model_reset();
    tick();
    $display("txn reset");
  endtask

  task automatic test_basic();
    run_cmd(6'd0, 32'h0, 1'b1, 1'b0);
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b0);
  endtask

  task automatic test_acmd41_init();
    for (int k = 0; k < 3; k++) begin
      run_cmd(6'd55, $urandom(), 1'b1, 1'b0);
      run_cmd(6'd41, 32'h4000_0000, 1'b1, 1'b0);
    end
    run_cmd(6'd58, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_drop();
    model_cmd(6'd8, 32'h0000_05C3, 1'b1);
    start_cmd(6'd8, 32'h0000_05C3, 1'b1, 1'b0);
    read_range(0, int'(TB_NCR) + 1, "drop_pre");
    start_cmd(6'd0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (io_Dropped !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: got %b expected 1", io_Dropped);
    end
    tick();
    checks++;
    if (io_Dropped !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear: got %b expected 0", io_Dropped);
    end
    read_range(int'(TB_NCR) + 1, exp_q.size(), "drop_post");
    check_end("drop");
    $display("txn drop during CMD8 send");
  endtask

  task automatic test_cs_high();
    io_CS = 1'b1;
    start_cmd(6'd55, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({io_Busy, io_Dropped, io_AppCmd} !== 3'b000) begin
      errors++;
      $display("FAIL cs_high: busy/drop/app got %b expected 000", {io_Busy, io_Dropped, io_AppCmd});
    end
    io_CS = 1'b0;
    tick();
    $display("txn cmd55 ignored with CS high");
  endtask

  task automatic test_illegal_and_crc();
    run_cmd(6'd0, 32'h0, 1'b1, 1'b0);
    run_cmd(6'd41, 32'h0, 1'b1, 1'b0);
    run_cmd(6'd16, 32'h200, 1'b0, 1'b0);
    run_cmd(6'd55, 32'h0, 1'b1, 1'b0);
    run_cmd(6'd16, 32'h200, 1'b1, 1'b0);
  endtask

  task automatic test_cs_abort();
    model_cmd(6'd8, 32'h0000_01AA, 1'b1);
    start_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b0);
    read_range(0, int'(TB_NCR) + 1, "abort_pre");
    repeat (4) strobe_bit();
    io_CS = 1'b1;
    tick();
    checks++;
    if ({io_DO, io_Busy} !== 2'b10) begin
      errors++;
      $display("FAIL cs_abort: do/busy got %b expected 10", {io_DO, io_Busy});
    end
    io_CS = 1'b0;
    tick();
    check_end("cs_abort");
    $display("txn CMD8 aborted by CS");
  endtask

  task automatic test_idle_strobe();
    repeat (5) strobe_bit();
    check_end("idle_strobe");
    $display("txn strobes while idle");
  endtask

  task automatic test_random();
    logic [5:0]  cmd;
    logic [31:0] arg;
    bit          ok;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0:       cmd = 6'd0;
        1:       cmd = 6'd8;
        2:       cmd = 6'd16;
        3:       cmd = 6'd41;
        4, 7:    cmd = 6'd55;
        5:       cmd = 6'd58;
        default: cmd = 6'($urandom_range(0, 63));
      endcase
      arg = $urandom();
      ok  = ($urandom_range(0, 9) != 0);
      run_cmd(cmd, arg, ok, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    model_cmd(6'd55, 32'h0, 1'b1);
    start_cmd(6'd55, 32'h0, 1'b1, 1'b0);
    read_range(0, int'(TB_NCR), "rst_mid_pre");
    repeat (3) strobe_bit();
    reset = 1'b0;
    tick();
    checks++;
    if ({io_DO, io_Busy, io_InIdle, io_AppCmd, io_Dropped} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_mid: do/busy/idle/app/drop got %b expected 10100",
               {io_DO, io_Busy, io_InIdle, io_AppCmd, io_Dropped});
    end
    reset = 1'b1;
    model_reset();
    tick();
    $display("txn reset mid-response");
    run_cmd(6'd55, 32'h0, 1'b1, 1'b0);
    run_cmd(6'd41, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_acmd41_init();
    test_drop();
    test_cs_high();
    test_illegal_and_crc();
    test_cs_abort();
    test_idle_strobe();
    run_cmd(6'd16, 32'h200, 1'b1, 1'b1);
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
